// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  localparam int SA_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell shared across the datapath library.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, LSB first, one bit per clock.
// Optional signed-overflow flag enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);

  sa_state_t        state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             fa_s;
  logic             fa_c;
  logic             last;
  logic             load;
  logic             unused_acc_lsb;

  full_adder u_fa (
    .A   (a_sr[0]),
    .B   (b_sr[0]),
    .Cin (carry),
    .S   (fa_s),
    .Cout(fa_c)
  );

  // Sum bits enter at the top and walk down, so the LSB lands in bit 0 after WIDTH shifts.
  assign acc_nxt        = {fa_s, acc[WIDTH-1:1]};
  assign unused_acc_lsb = acc[0];
  assign last           = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
  assign load           = start && ((state == IDLE) || (state == DONE));
  assign busy           = (state == RUN);
  assign done           = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: state <= start ? RUN : IDLE;
        RUN: begin
          if (last) begin
            state <= DONE;
            sum   <= acc_nxt;
            cout  <= fa_c;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand shifters and bit counter carry no reset; a start always reloads them.
  always_ff @(posedge clk) begin
    if (load) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= cin;
      cnt   <= '0;
      acc   <= '0;
    end else if (state == RUN) begin
      acc   <= acc_nxt;
      carry <= fa_c;
      a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
      cnt   <= cnt + 1'b1;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic c_msb_in;

  // On the last RUN cycle the running carry is the carry into the MSB.
  assign c_msb_in = carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (last) begin
      ovf <= c_msb_in ^ fa_c;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks   = 0;
  int failures = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic c);
`ifdef SERIAL_ADDER_OVF_EN
    logic [W:0] r;
    r = model_add(x, y, c);
    return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
`else
    return 1'b0;
`endif
  endfunction

  // Present a start at the current negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    cin   = tc;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
  endtask

  // Expects W busy cycles then the done cycle; optionally pokes start mid-RUN.
  task automatic expect_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           input logic tc, input int poke_at);
    logic [W:0] r;
    r = model_add(ta, tb_v, tc);
    for (int i = 0; i < W; i++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_nodone"}, 32'(done), 32'd0);
      if (i == poke_at) begin
        start = 1'b1;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_idlebusy"}, 32'(busy), 32'd0);
    chk({tag, "_sum"}, 32'(sum), 32'(r[W-1:0]));
    chk({tag, "_cout"}, 32'(cout), 32'(r[W]));
    chk({tag, "_ovf"}, 32'(ovf), 32'(model_ovf(ta, tb_v, tc)));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic [W:0]   hold_r;
    int           done_seen;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    launch(8'h00, 8'h00, 1'b0);
    expect_op("zero", 8'h00, 8'h00, 1'b0, -1);
    @(negedge clk);

    launch(8'hFF, 8'h01, 1'b0);
    expect_op("wrap", 8'hFF, 8'h01, 1'b0, -1);
    @(negedge clk);
    chk("wrap_done_pulse", 32'(done), 32'd0);
    chk("wrap_hold_sum", 32'(sum), 32'h00);
    chk("wrap_hold_cout", 32'(cout), 32'd1);

    launch(8'h7F, 8'h01, 1'b0);
    expect_op("sovf", 8'h7F, 8'h01, 1'b0, -1);
    @(negedge clk);

    // Back-to-back: restart during the DONE cycle.
    launch(8'hA5, 8'h5A, 1'b1);
    expect_op("cin", 8'hA5, 8'h5A, 1'b1, -1);
    launch(8'h03, 8'h04, 1'b0);
    expect_op("b2b", 8'h03, 8'h04, 1'b0, -1);
    @(negedge clk);

    launch(8'h12, 8'h34, 1'b0);
    expect_op("ignore_start", 8'h12, 8'h34, 1'b0, 3);
    @(negedge clk);

    // Reset in the middle of RUN.
    launch(8'hC3, 8'h3C, 1'b1);
    repeat (3) @(negedge clk);
    chk("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    chk("midrst_no_done", 32'(done_seen), 32'd0);

    launch(8'h80, 8'h80, 1'b0);
    expect_op("after_rst", 8'h80, 8'h80, 1'b0, -1);
    @(negedge clk);

    // Random operations with random idle gaps or back-to-back restarts.
    for (int n = 0; n < 12; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      launch(ra, rb, rc);
      expect_op("rand", ra, rb, rc, (n % 3 == 0) ? int'($urandom_range(0, 6)) : -1);
      if ($urandom_range(0, 1) == 1) begin
        hold_r = model_add(ra, rb, rc);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        chk("rand_hold_sum", 32'(sum), 32'(hold_r[W-1:0]));
        chk("rand_idle_done", 32'(done), 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
